hamming_decodificador: RTL and testbench
========================================

Name: hamming_decodificador

Overview:
- Pipelined Hamming(15,11) decoder and single-error corrector.
- Sits directly downstream of the error injector: consumes the 15-bit codeword (possibly carrying one flipped bit) and produces the corrected 11-bit data word.
- Also outputs the syndrome, a corrected flag and a saturating count of corrected words.
- Uses a valid/ready handshake on both sides, so a slow consumer can stall it.

Parameters:
- CONT_W, 16, width of the saturating corrected-word counter (min 2).

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- entrada_valida  input  1  upstream codeword valid
- entrada_pronta  output  1  block can accept a codeword this cycle
- entrada  input  15  codeword; entrada[n-1] is Hamming position n (1..15)
- saida_valida  output  1  decoded word valid
- saida_pronta  input  1  downstream accepts decoded word
- dado  output  11  corrected data bits
- corrigido  output  1  1 = nonzero syndrome, one bit was flipped back
- sindrome  output  4  syndrome of the received word (0 = no error)
- limpar_contagem  input  1  synchronous clear of contagem_correcoes
- contagem_correcoes  output  CONT_W  number of corrected words delivered

Behaviour:
- Code layout:
  - Parity bits sit at positions 1, 2, 4, 8.
  - Data bits in position order: dado[0]=pos3, dado[1]=pos5, dado[2]=pos6, dado[3]=pos7, dado[4..10]=pos9..pos15.
  - Even parity.
- Syndrome: sindrome[i] = XOR of entrada[p-1] over every position p (1..15) with bit i of p set.
- Correction:
  - If sindrome != 0, invert position sindrome, then extract data.
  - Every nonzero syndrome is treated as a single error. Double errors are not detected and miscorrect silently.
- Stage 1 (S1): on transfer in (entrada_valida & entrada_pronta), register the codeword and its syndrome. Set v1.
- Stage 2 (S2): register the corrected data, corrigido and sindrome from S1. Set v2. saida_valida = v2.
- Latency: 2 cycles from an accepted input to saida_valida. Throughput is 1 word/cycle with no stall.
- Handshake:
  - pronta2 = !v2 | saida_pronta.
  - entrada_pronta = !v1 | pronta2 (combinational from saida_pronta).
  - S2 loads when pronta2; v2 takes v1.
  - S1 loads when entrada_pronta; v1 takes entrada_valida.
  - While saida_valida=1 and saida_pronta=0, dado, corrigido and sindrome hold stable.
  - Data registers may load garbage only when their valid bit is 0.
- Full stall: v1=v2=1 with saida_pronta=0 drops entrada_pronta to 0. No word is lost or duplicated.
- Simultaneous in/out: with both stages full and saida_pronta=1, one word leaves and one enters in the same cycle.
- Counter:
  - Increments by 1 on an output transfer (saida_valida & saida_pronta) with corrigido=1.
  - Saturates at 2^CONT_W-1; no wrap.
  - limpar_contagem has priority: a clear in the same cycle as an increment yields 0.
- Reset (async assert, any time including mid-stream):
  - v1=v2=0, saida_valida=0, dado=0, corrigido=0, sindrome=0, contagem_correcoes=0.
  - In-flight words are discarded.
  - entrada_pronta=1 while rst_n=0 is not required; it must be 1 the first cycle after release.

Decomposition:
- Package hamming_pkg:
  - constants N=15, K=11, R=4.
  - data-position table (dado index -> Hamming position).
  - function extraindo 11 data bits from a 15-bit word.
- Sub-module hamming_sindrome: combinational 15-bit in, 4-bit syndrome out. It is reused by the checker in the bench.

Test Plan:
- Clean words: entrada=15'h0000, then 15'h7FFF, saida_pronta=1 -> after 2 cycles:
  - dado=11'h000, corrigido=0, sindrome=0.
  - next dado=11'h7FF, corrigido=0.
- Single error, all-zero word: entrada=15'h0010 (pos5 flipped) -> sindrome=4'd5, corrigido=1, dado=11'h000, contagem_correcoes=1.
- Error on a parity/data bit of the all-ones word:
  - 15'h7FFE -> sindrome=1, dado=11'h7FF.
  - 15'h3FFF -> sindrome=15, dado=11'h7FF.
- Backpressure: saida_pronta=0, present 3 valid words back-to-back.
  - entrada_pronta drops after 2 are accepted; outputs hold.
  - Raise saida_pronta -> words emerge in order, none lost or duplicated.
- Counter: CONT_W=2, 5 corrected words -> saturates at 3. Pulse limpar_contagem on the same cycle as a corrected transfer -> 0.
- Reset mid-operation: assert rst_n=0 with v1=v2=1 -> saida_valida=0 and contagem_correcoes=0 immediately. After release, the next word decodes with 2-cycle latency.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared constants and helpers for the Hamming(15,11) decoder slice.
// Positions are 1-based Hamming positions; bit n-1 of a word holds position n.
package hamming_pkg;

  localparam int N = 15;
  localparam int K = 11;
  localparam int R = 4;

  // dado index -> Hamming position (every non-power-of-two position, in order)
  localparam int POS_DADO [K] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  // Positions covered by syndrome bit bit_idx: those whose index has that bit set.
  function automatic logic [N-1:0] mascara_sindrome(input int bit_idx);
    logic [N-1:0] m;
    m = '0;
    for (int p = 1; p <= N; p++) begin
      if (((p >> bit_idx) & 1) != 0) m[p-1] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [K-1:0] extrai_dado(input logic [N-1:0] palavra);
    logic [K-1:0] d;
    for (int k = 0; k < K; k++) begin
      d[k] = palavra[POS_DADO[k]-1];
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_sindrome.sv
// Combinational syndrome of a 15-bit Hamming codeword (even parity).
// A zero result means the word is consistent.
module hamming_sindrome
  import hamming_pkg::*;
(
  input  logic [N-1:0] palavra,
  output logic [R-1:0] sindrome
);

  for (genvar gi = 0; gi < R; gi++) begin : g_bit
    localparam logic [N-1:0] MASCARA = mascara_sindrome(gi);
    assign sindrome[gi] = ^(palavra & MASCARA);
  end

endmodule

// File: rtl/hamming_decodificador.sv
// Two-stage pipelined Hamming(15,11) single-error corrector with valid/ready
// handshake on both sides and a saturating count of corrected words.
module hamming_decodificador
  import hamming_pkg::*;
#(
  parameter int CONT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              entrada_valida,
  output logic              entrada_pronta,
  input  logic [N-1:0]      entrada,
  output logic              saida_valida,
  input  logic              saida_pronta,
  output logic [K-1:0]      dado,
  output logic              corrigido,
  output logic [R-1:0]      sindrome,
  input  logic              limpar_contagem,
  output logic [CONT_W-1:0] contagem_correcoes
);

  logic              pronta2;
  logic [R-1:0]      sind_entrada;
  logic              v1_reg;
  logic [N-1:0]      palavra1_reg;
  logic [R-1:0]      sind1_reg;
  logic              v2_reg;
  logic [K-1:0]      dado2_reg;
  logic              corr2_reg;
  logic [R-1:0]      sind2_reg;
  logic [CONT_W-1:0] contagem_reg;
  logic [N-1:0]      mascara;
  logic [N-1:0]      corrigida;

  hamming_sindrome u_sindrome (
    .palavra  (entrada),
    .sindrome (sind_entrada)
  );

  assign pronta2        = !v2_reg || saida_pronta;
  assign entrada_pronta = !v1_reg || pronta2;

  // One-hot flip mask: the syndrome names the position to invert (0 = none).
  for (genvar gi = 0; gi < N; gi++) begin : g_mascara
    assign mascara[gi] = (sind1_reg == R'(gi + 1));
  end
  assign corrigida = palavra1_reg ^ mascara;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg       <= 1'b0;
      palavra1_reg <= '0;
      sind1_reg    <= '0;
    end else if (entrada_pronta) begin
      v1_reg <= entrada_valida;
      if (entrada_valida) begin
        palavra1_reg <= entrada;
        sind1_reg    <= sind_entrada;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg    <= 1'b0;
      dado2_reg <= '0;
      corr2_reg <= 1'b0;
      sind2_reg <= '0;
    end else if (pronta2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        dado2_reg <= extrai_dado(corrigida);
        corr2_reg <= (sind1_reg != '0);
        sind2_reg <= sind1_reg;
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contagem_reg <= '0;
    end else if (limpar_contagem) begin
      contagem_reg <= '0;
    end else if (v2_reg && saida_pronta && corr2_reg && (contagem_reg != {CONT_W{1'b1}})) begin
      contagem_reg <= contagem_reg + 1'b1;
    end
  end

  assign saida_valida       = v2_reg;
  assign dado               = dado2_reg;
  assign corrigido          = corr2_reg;
  assign sindrome           = sind2_reg;
  assign contagem_correcoes = contagem_reg;

endmodule

// File: tb/tb_hamming_decodificador.sv
// Randomized plus directed bench for hamming_decodificador against a
// position-arithmetic reference model and an in-order result queue.
module tb_hamming_decodificador;

  localparam int CONT_W = 2;
  localparam int CNT_MAX = (1 << CONT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              entrada_valida = 1'b0;
  logic              entrada_pronta;
  logic [14:0]       entrada = '0;
  logic              saida_valida;
  logic              saida_pronta = 1'b0;
  logic [10:0]       dado;
  logic              corrigido;
  logic [3:0]        sindrome;
  logic              limpar_contagem = 1'b0;
  logic [CONT_W-1:0] contagem_correcoes;
  logic [14:0]       chk_word = '0;
  logic [3:0]        chk_s;

  typedef struct packed {
    logic [10:0] d;
    logic        c;
    logic [3:0]  s;
  } res_t;

  res_t        fila[$];
  int          cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [10:0] last_d;
  logic        last_c;
  logic [3:0]  last_s;

  hamming_decodificador #(.CONT_W(CONT_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .entrada_valida     (entrada_valida),
    .entrada_pronta     (entrada_pronta),
    .entrada            (entrada),
    .saida_valida       (saida_valida),
    .saida_pronta       (saida_pronta),
    .dado               (dado),
    .corrigido          (corrigido),
    .sindrome           (sindrome),
    .limpar_contagem    (limpar_contagem),
    .contagem_correcoes (contagem_correcoes)
  );

  hamming_sindrome u_chk (
    .palavra  (chk_word),
    .sindrome (chk_s)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  // Syndrome as the XOR of the positions of all set bits.
  function automatic int ref_sind(input logic [14:0] w);
    int s;
    s = 0;
    for (int p = 1; p <= 15; p++) if (w[p-1]) s = s ^ p;
    return s;
  endfunction

  function automatic res_t ref_dec(input logic [14:0] w);
    res_t r;
    int   s;
    int   k;
    s = ref_sind(w);
    if (s != 0) w[s-1] = ~w[s-1];
    k = 0;
    r.d = '0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        r.d[k] = w[p-1];
        k++;
      end
    end
    r.c = (s != 0);
    r.s = 4'(s);
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check, predict, advance.
  task automatic step(input logic v, input logic [14:0] w, input logic sp,
                      input logic clr, input int exp_sv);
    res_t r;
    logic in_fire;
    logic out_fire;
    entrada_valida  = v;
    entrada         = w;
    saida_pronta    = sp;
    limpar_contagem = clr;
    chk_word        = w;
    #1;
    check_val("entrada_pronta", entrada_pronta, (fila.size() == 2 && !sp) ? 0 : 1);
    if (fila.size() == 2) check_val("saida_valida_full", saida_valida, 1);
    else if (fila.size() == 0) check_val("saida_valida_empty", saida_valida, 0);
    if (exp_sv >= 0) check_val("latency_valid", saida_valida, exp_sv);
    check_val("contagem", contagem_correcoes, cnt);
    check_val("chk_sindrome", chk_s, ref_sind(w));
    in_fire  = v && entrada_pronta;
    out_fire = saida_valida && sp;
    if (out_fire && fila.size() > 0) begin
      r = fila.pop_front();
      check_val("dado", dado, r.d);
      check_val("corrigido", corrigido, r.c);
      check_val("sindrome", sindrome, r.s);
      last_d = dado;
      last_c = corrigido;
      last_s = sindrome;
      $display("out dado=%h corrigido=%0d sindrome=%0d", dado, corrigido, sindrome);
      if (r.c && cnt < CNT_MAX) cnt++;
    end
    if (clr) cnt = 0;
    if (in_fire) fila.push_back(ref_dec(w));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_saida_valida", saida_valida, 0);
    check_val("rst_dado", dado, 0);
    check_val("rst_corrigido", corrigido, 0);
    check_val("rst_sindrome", sindrome, 0);
    check_val("rst_contagem", contagem_correcoes, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean words
    step(1, 15'h0000, 1, 0, -1);
    step(1, 15'h7FFF, 1, 0, 0);
    step(0, 15'h0000, 1, 0, 1);
    check_val("clean0_dado", last_d, 11'h000);
    check_val("clean0_corr", last_c, 0);
    check_val("clean0_sind", last_s, 0);
    step(0, 15'h0000, 1, 0, 1);
    check_val("clean1_dado", last_d, 11'h7FF);
    check_val("clean1_corr", last_c, 0);

    // Single error on the all-zero word
    step(1, 15'h0010, 1, 0, -1);
    step(0, 15'h0000, 1, 0, 0);
    step(0, 15'h0000, 1, 0, 1);
    check_val("pos5_sind", last_s, 5);
    check_val("pos5_corr", last_c, 1);
    check_val("pos5_dado", last_d, 11'h000);
    check_val("pos5_contagem", contagem_correcoes, 1);

    // Parity-bit and top-data-bit errors on the all-ones word
    step(1, 15'h7FFE, 1, 0, -1);
    step(1, 15'h3FFF, 1, 0, 0);
    step(0, 15'h0000, 1, 0, 1);
    check_val("pos1_sind", last_s, 1);
    check_val("pos1_dado", last_d, 11'h7FF);
    step(0, 15'h0000, 1, 0, 1);
    check_val("pos15_sind", last_s, 15);
    check_val("pos15_dado", last_d, 11'h7FF);
    step(0, 15'h0000, 1, 1, -1);

    // Backpressure: third word refused until the consumer is ready
    step(1, 15'h1234, 0, 0, -1);
    step(1, 15'h0F0F, 0, 0, 0);
    step(1, 15'h5555, 0, 0, 1);
    check_val("bp_pronta_low", entrada_pronta, 0);
    step(1, 15'h5555, 0, 0, 1);
    step(1, 15'h5555, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 15'h0000, 1, 0, -1);
    check_val("bp_drained", fila.size(), 0);

    // Saturation at 2^CONT_W-1, then clear on a corrected transfer
    step(0, 15'h0000, 1, 1, -1);
    for (int i = 0; i < 5; i++) step(1, 15'(15'h0001 << i), 1, 0, -1);
    for (int i = 0; i < 3; i++) step(0, 15'h0000, 1, 0, -1);
    check_val("sat_contagem", contagem_correcoes, CNT_MAX);
    step(1, 15'h0100, 0, 0, -1);
    step(0, 15'h0000, 0, 0, 0);
    step(0, 15'h0000, 1, 1, 1);
    check_val("clr_on_transfer", contagem_correcoes, 0);

    // Reset with both stages full
    step(1, 15'h0020, 1, 0, -1);
    step(0, 15'h0000, 1, 0, -1);
    step(0, 15'h0000, 1, 0, -1);
    step(1, 15'h0100, 0, 0, -1);
    step(1, 15'h0200, 0, 0, -1);
    check_val("pre_rst_full", saida_valida, 1);
    entrada_valida = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("midrst_saida_valida", saida_valida, 0);
    check_val("midrst_contagem", contagem_correcoes, 0);
    check_val("midrst_sindrome", sindrome, 0);
    fila.delete();
    cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 15'h4000, 1, 0, 0);
    step(0, 15'h0000, 1, 0, 0);
    step(0, 15'h0000, 1, 0, 1);
    check_val("postrst_sind", last_s, 15);
    check_val("postrst_dado", last_d, 11'h000);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           15'($urandom_range(0, 32767)),
           ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
           -1);
    end
    for (int i = 0; i < 10 && fila.size() > 0; i++) step(0, 15'h0000, 1, 0, -1);
    check_val("final_drained", fila.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
